// File: rtl/master_start_loader.sv
// Command-frame loader feeding the MASTER_START parameter-write interface.
// Define LOADER_CHECKSUM_EN to expect and verify a trailing CSUM byte per frame.
//
// state     | meaning
// S_IDLE    | hunt for HDR, drop anything else
// S_CMD     | decode command, load payload byte counter
// S_PAYLOAD | shift payload bytes into the shadow register
// S_CSUM    | compare received CSUM with running sum (checksum build only)
// S_COMMIT  | shadow now visible on outputs, frame_ok high
// S_WR      | WR_DATA strobe for burst parameters
module master_start_loader #(
   parameter int unsigned TIMEOUT = 48000,
   parameter logic [7:0]  HDR     = 8'hA5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        SYS_TIME_UPDATE_OK,
   output logic [47:0] MEM_DDS_freq,
   output logic [47:0] MEM_DDS_delta_freq,
   output logic [31:0] MEM_DDS_delta_rate,
   output logic [63:0] MEM_TIME_START,
   output logic [15:0] MEM_N_impuls,
   output logic [1:0]  MEM_TYPE_impulse,
   output logic [31:0] MEM_Interval_Ti,
   output logic [31:0] MEM_Interval_Tp,
   output logic [31:0] MEM_Tblank1,
   output logic [31:0] MEM_Tblank2,
   output logic        WR_DATA,
   output logic [63:0] SYS_TIME,
   output logic        SYS_TIME_UPDATE,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   localparam int unsigned     GW       = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0]   GAP_LAST = GW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_PAYLOAD, S_CSUM, S_COMMIT, S_WR
   } state_t;

   state_t         r_state, w_state_next;
   logic [5:0]     r_cnt;
   logic           r_is_time;
   logic [GW-1:0]  r_gap;
   logic [335:0]   r_shadow;
   logic [343:0]   w_shadow_cur;
   logic           w_rx_ready, w_accept, w_err, w_commit, w_timeout;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]     r_sum;
   logic [7:0]     r_last;
`endif

   // The final payload byte is held in r_last when a CSUM byte still follows;
   // without checksum it is taken straight from rx_data on the committing edge.
`ifdef LOADER_CHECKSUM_EN
   assign w_shadow_cur = {r_shadow, r_last};
`else
   assign w_shadow_cur = {r_shadow, rx_data};
`endif

   assign w_accept  = rx_valid && w_rx_ready;
   assign w_timeout = (r_gap == GAP_LAST);
   assign rx_ready  = w_rx_ready;
   assign frame_ok  = (r_state == S_COMMIT);
   assign WR_DATA   = (r_state == S_WR);

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_rx_ready   = 1'b0;
      w_err        = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rx_ready = 1'b1;
            if (rx_valid && rx_data == HDR) w_state_next = S_CMD;
         end
         S_CMD: begin
            w_rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_data == 8'h01 || rx_data == 8'h02) begin
                  w_state_next = S_PAYLOAD;
               end else begin
                  w_err        = 1'b1;
                  w_state_next = S_IDLE;
               end
            end else if (w_timeout) begin
               w_err        = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_PAYLOAD: begin
            w_rx_ready = 1'b1;
            if (rx_valid) begin
               if (r_cnt == 6'd1) begin
`ifdef LOADER_CHECKSUM_EN
                  w_state_next = S_CSUM;
`else
                  w_commit     = 1'b1;
                  w_state_next = S_COMMIT;
`endif
               end
            end else if (w_timeout) begin
               w_err        = 1'b1;
               w_state_next = S_IDLE;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            w_rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_data == r_sum) begin
                  w_commit     = 1'b1;
                  w_state_next = S_COMMIT;
               end else begin
                  w_err        = 1'b1;
                  w_state_next = S_IDLE;
               end
            end else if (w_timeout) begin
               w_err        = 1'b1;
               w_state_next = S_IDLE;
            end
         end
`endif
         S_COMMIT: w_state_next = r_is_time ? S_IDLE : S_WR;
         S_WR:     w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt              <= '0;
         r_is_time          <= 1'b0;
         r_gap              <= '0;
         r_shadow           <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_sum              <= '0;
         r_last             <= '0;
`endif
         MEM_DDS_freq       <= '0;
         MEM_DDS_delta_freq <= '0;
         MEM_DDS_delta_rate <= '0;
         MEM_TIME_START     <= '0;
         MEM_N_impuls       <= '0;
         MEM_TYPE_impulse   <= '0;
         MEM_Interval_Ti    <= '0;
         MEM_Interval_Tp    <= '0;
         MEM_Tblank1        <= '0;
         MEM_Tblank2        <= '0;
         SYS_TIME           <= '0;
         SYS_TIME_UPDATE    <= 1'b0;
         frame_err          <= 1'b0;
         err_cnt            <= '0;
      end else begin
         frame_err <= w_err;
         if (w_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

         if (w_accept || r_state == S_IDLE || !w_rx_ready) r_gap <= '0;
         else                                              r_gap <= r_gap + 1'b1;

         if (w_accept && r_state == S_CMD) begin
            r_is_time <= (rx_data == 8'h02);
            r_cnt     <= (rx_data == 8'h02) ? 6'd8 : 6'd43;
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= rx_data;
`endif
         end

         if (w_accept && r_state == S_PAYLOAD) begin
            r_shadow <= w_shadow_cur[335:0];
            r_cnt    <= r_cnt - 6'd1;
`ifdef LOADER_CHECKSUM_EN
            r_last   <= rx_data;
            r_sum    <= r_sum + rx_data;
`endif
         end

         if (w_commit) begin
            if (r_is_time) begin
               SYS_TIME <= w_shadow_cur[63:0];
            end else begin
               MEM_DDS_freq       <= w_shadow_cur[343:296];
               MEM_DDS_delta_freq <= w_shadow_cur[295:248];
               MEM_DDS_delta_rate <= w_shadow_cur[247:216];
               MEM_TIME_START     <= w_shadow_cur[215:152];
               MEM_N_impuls       <= w_shadow_cur[151:136];
               MEM_TYPE_impulse   <= w_shadow_cur[129:128];
               MEM_Interval_Ti    <= w_shadow_cur[127:96];
               MEM_Interval_Tp    <= w_shadow_cur[95:64];
               MEM_Tblank1        <= w_shadow_cur[63:32];
               MEM_Tblank2        <= w_shadow_cur[31:0];
            end
         end

         // A fresh preset commit outranks an acknowledge landing on the same edge.
         if (w_commit && r_is_time)   SYS_TIME_UPDATE <= 1'b1;
         else if (SYS_TIME_UPDATE_OK) SYS_TIME_UPDATE <= 1'b0;
      end
   end

endmodule

// File: tb/tb_master_start_loader.sv
// Randomized frame-level bench for master_start_loader; expected register contents
// come from the field values the bench itself packs into each frame.
module tb_master_start_loader;
   localparam int         TO = 40;
   localparam logic [7:0] HB = 8'hA5;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        SYS_TIME_UPDATE_OK = 1'b0;
   logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq;
   logic [31:0] MEM_DDS_delta_rate;
   logic [63:0] MEM_TIME_START;
   logic [15:0] MEM_N_impuls;
   logic [1:0]  MEM_TYPE_impulse;
   logic [31:0] MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
   logic        WR_DATA;
   logic [63:0] SYS_TIME;
   logic        SYS_TIME_UPDATE, frame_ok, frame_err;
   logic [7:0]  err_cnt;

   master_start_loader #(.TIMEOUT(TO), .HDR(HB)) dut (
      .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK),
      .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
      .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
      .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
      .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
      .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2),
      .WR_DATA(WR_DATA), .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;
   int wr_seen = 0, ok_seen = 0, ferr_seen = 0;

   always @(negedge CLK) begin
      if (WR_DATA)   wr_seen   = wr_seen + 1;
      if (frame_ok)  ok_seen   = ok_seen + 1;
      if (frame_err) ferr_seen = ferr_seen + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // frame under construction (p_*) and what the outputs should hold (m_*)
   logic [47:0] p_freq, p_dfreq, m_freq, m_dfreq;
   logic [31:0] p_rate, p_ti, p_tp, p_b1, p_b2, m_rate, m_ti, m_tp, m_b1, m_b2;
   logic [63:0] p_ts, m_ts, m_st;
   logic [15:0] p_n, m_n;
   logic [7:0]  p_ty;
   logic [1:0]  m_type;
   int          m_errs;
   logic [7:0]  frm[$];
   logic [7:0]  f1[$];

   task automatic model_clear();
      m_freq = '0; m_dfreq = '0; m_rate = '0; m_ts = '0; m_n = '0; m_type = '0;
      m_ti = '0; m_tp = '0; m_b1 = '0; m_b2 = '0; m_st = '0; m_errs = 0;
   endtask

   task automatic model_take01();
      m_freq = p_freq; m_dfreq = p_dfreq; m_rate = p_rate; m_ts = p_ts; m_n = p_n;
      m_type = p_ty[1:0]; m_ti = p_ti; m_tp = p_tp; m_b1 = p_b1; m_b2 = p_b2;
   endtask

   task automatic model_err();
      if (m_errs < 255) m_errs++;
   endtask

   task automatic rand01();
      p_freq = 48'({$urandom, $urandom}); p_dfreq = 48'({$urandom, $urandom});
      p_rate = $urandom; p_ts = {$urandom, $urandom}; p_n = 16'($urandom);
      p_ty = 8'($urandom); p_ti = $urandom; p_tp = $urandom; p_b1 = $urandom; p_b2 = $urandom;
   endtask

   task automatic put(input logic [63:0] v, input int nb);
      for (int i = nb - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
   endtask

   task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] s;
      s = 8'h00;
      for (int i = 1; i < frm.size(); i++) s = s + frm[i];
      frm.push_back(s);
`endif
   endtask

   task automatic build01();
      frm.delete();
      frm.push_back(HB); frm.push_back(8'h01);
      put(64'(p_freq), 6); put(64'(p_dfreq), 6); put(64'(p_rate), 4); put(p_ts, 8);
      put(64'(p_n), 2); put(64'(p_ty), 1); put(64'(p_ti), 4); put(64'(p_tp), 4);
      put(64'(p_b1), 4); put(64'(p_b2), 4);
      add_csum();
   endtask

   task automatic build02(input logic [63:0] t);
      frm.delete();
      frm.push_back(HB); frm.push_back(8'h02);
      put(t, 8);
      add_csum();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output int stalls);
      bit rdy, done;
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) @(negedge CLK);
      end
      rx_data = b; rx_valid = 1'b1; stalls = 0; done = 1'b0;
      while (!done && stalls < 100) begin
         rdy = rx_ready;
         @(negedge CLK);
         if (rdy) done = 1'b1;
         else     stalls++;
      end
      if (!done) chk("byte_accept", 64'(done), 64'd1);
   endtask

   task automatic send_frame(input int maxgap, input int long_at, input bit drop,
                             input int probe_at, output int probe_stall);
      int g, st;
      probe_stall = -1;
      for (int i = 0; i < frm.size(); i++) begin
         g = 0;
         if (maxgap > 0) g = int'($urandom_range(maxgap, 0));
         if (i == long_at) g = TO - 2;
         send_byte(frm[i], g, st);
         if (i == probe_at) probe_stall = st;
      end
      if (drop) rx_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   task automatic check_mem(input string tag);
      chk({tag, "_freq"},  64'(MEM_DDS_freq),       64'(m_freq));
      chk({tag, "_dfreq"}, 64'(MEM_DDS_delta_freq), 64'(m_dfreq));
      chk({tag, "_rate"},  64'(MEM_DDS_delta_rate), 64'(m_rate));
      chk({tag, "_ts"},    MEM_TIME_START,          m_ts);
      chk({tag, "_n"},     64'(MEM_N_impuls),       64'(m_n));
      chk({tag, "_type"},  64'(MEM_TYPE_impulse),   64'(m_type));
      chk({tag, "_ti"},    64'(MEM_Interval_Ti),    64'(m_ti));
      chk({tag, "_tp"},    64'(MEM_Interval_Tp),    64'(m_tp));
      chk({tag, "_tb1"},   64'(MEM_Tblank1),        64'(m_b1));
      chk({tag, "_tb2"},   64'(MEM_Tblank2),        64'(m_b2));
   endtask

   // Called on the falling edge right after the frame's last byte was taken.
   task automatic expect_commit01(input string tag);
      model_take01();
      chk({tag, "_ok"}, 64'(frame_ok), 64'd1);
      chk({tag, "_wr_early"}, 64'(WR_DATA), 64'd0);
      chk({tag, "_rdy_n1"}, 64'(rx_ready), 64'd0);
      check_mem(tag);
      @(negedge CLK);
      chk({tag, "_wr"}, 64'(WR_DATA), 64'd1);
      chk({tag, "_rdy_n2"}, 64'(rx_ready), 64'd0);
      chk({tag, "_ok_once"}, 64'(frame_ok), 64'd0);
      @(negedge CLK);
      chk({tag, "_wr_end"}, 64'(WR_DATA), 64'd0);
      chk({tag, "_rdy_n3"}, 64'(rx_ready), 64'd1);
   endtask

   task automatic good01(input string tag, input int maxgap, input int long_at);
      int ps;
      build01();
      send_frame(maxgap, long_at, 1'b1, -1, ps);
      expect_commit01(tag);
   endtask

   initial begin
      int wr0, ok0, fe0, ps, n, st;
      bit fired;
      logic [63:0] t;

      model_clear();
      repeat (3) @(negedge CLK);
      check_mem("rst");
      chk("rst_systime", SYS_TIME, 64'd0);
      chk("rst_upd", 64'(SYS_TIME_UPDATE), 64'd0);
      chk("rst_wr", 64'(WR_DATA), 64'd0);
      chk("rst_ok", 64'(frame_ok), 64'd0);
      chk("rst_ferr", 64'(frame_err), 64'd0);
      chk("rst_errcnt", 64'(err_cnt), 64'd0);
      chk("rst_rdy", 64'(rx_ready), 64'd1);
      RESET = 1'b0;
      @(negedge CLK);

      // reference burst frame
      p_freq = 48'h001000000000; p_dfreq = 48'h000000100000; p_rate = 32'h100;
      p_ts = 64'h12C0; p_n = 16'd1; p_ty = 8'h00; p_ti = 32'h1800; p_tp = 32'h1800;
      p_b1 = 32'h180; p_b2 = 32'h180;
      settle(0); wr0 = wr_seen;
      good01("f1", 0, -1);
      settle(2);
      chk("f1_wr_count", 64'(wr_seen - wr0), 64'd1);
      chk("f1_errcnt", 64'(err_cnt), 64'(m_errs));

`ifdef LOADER_CHECKSUM_EN
      rand01(); build01();
      frm[frm.size() - 1] = frm[frm.size() - 1] + 8'd1;
      wr0 = wr_seen; fe0 = ferr_seen;
      send_frame(0, -1, 1'b1, -1, ps);
      chk("badcs_ferr", 64'(frame_err), 64'd1);
      chk("badcs_ok", 64'(frame_ok), 64'd0);
      model_err();
      settle(4);
      chk("badcs_wr_count", 64'(wr_seen - wr0), 64'd0);
      chk("badcs_ferr_count", 64'(ferr_seen - fe0), 64'd1);
      chk("badcs_errcnt", 64'(err_cnt), 64'(m_errs));
      check_mem("badcs");
`endif

      // timeout after 20 payload bytes
      rand01(); build01();
      wr0 = wr_seen;
      for (int i = 0; i < 22; i++) send_byte(frm[i], 0, st);
      rx_valid = 1'b0;
      n = 1; fired = 1'b0;
      while (!fired && n < 3 * TO) begin
         @(negedge CLK);
         n++;
         if (frame_err) fired = 1'b1;
      end
      chk("to_fired", 64'(fired), 64'd1);
      chk("to_window", 64'(n >= TO && n <= TO + 1), 64'd1);
      model_err();
      settle(2);
      chk("to_errcnt", 64'(err_cnt), 64'(m_errs));
      chk("to_wr_count", 64'(wr_seen - wr0), 64'd0);
      chk("to_rdy", 64'(rx_ready), 64'd1);
      check_mem("to_keep");
      rand01();
      good01("after_to", 0, -1);

      // time preset handshake
      build02(64'h5);
      send_frame(0, -1, 1'b1, -1, ps);
      m_st = 64'h5;
      chk("st_upd", 64'(SYS_TIME_UPDATE), 64'd1);
      chk("st_val", SYS_TIME, m_st);
      chk("st_ok", 64'(frame_ok), 64'd1);
      @(negedge CLK);
      chk("st_no_wr", 64'(WR_DATA), 64'd0);
      settle(3);
      chk("st_held", 64'(SYS_TIME_UPDATE), 64'd1);
      check_mem("st_memkeep");
      SYS_TIME_UPDATE_OK = 1'b1;
      @(negedge CLK);
      SYS_TIME_UPDATE_OK = 1'b0;
      chk("st_ack_clear", 64'(SYS_TIME_UPDATE), 64'd0);
      chk("st_after_ack", SYS_TIME, 64'h5);

      t = {$urandom, $urandom}; build02(t);
      send_frame(1, -1, 1'b1, -1, ps);
      t = {$urandom, $urandom}; build02(t);
      send_frame(1, -1, 1'b1, -1, ps);
      m_st = t;
      chk("st_overwrite", SYS_TIME, m_st);
      chk("st_overwrite_upd", 64'(SYS_TIME_UPDATE), 64'd1);
      SYS_TIME_UPDATE_OK = 1'b1;
      t = {$urandom, $urandom}; build02(t);
      send_frame(0, -1, 1'b1, -1, ps);
      m_st = t;
      chk("st_race_upd", 64'(SYS_TIME_UPDATE), 64'd1);
      chk("st_race_val", SYS_TIME, m_st);
      @(negedge CLK);
      chk("st_race_clear", 64'(SYS_TIME_UPDATE), 64'd0);
      SYS_TIME_UPDATE_OK = 1'b0;

      // stray bytes, then unknown command
      fe0 = ferr_seen;
      send_byte(8'h00, 0, st); send_byte(8'h5A, 0, st); send_byte(8'hFF, 0, st);
      send_byte(HB, 0, st); send_byte(8'h7F, 0, st);
      rx_valid = 1'b0;
      chk("badcmd_ferr", 64'(frame_err), 64'd1);
      model_err();
      settle(2);
      chk("badcmd_ferr_count", 64'(ferr_seen - fe0), 64'd1);
      chk("badcmd_errcnt", 64'(err_cnt), 64'(m_errs));
      rand01();
      good01("after_badcmd", 2, -1);

      // back-to-back frames with rx_valid held high
      rand01(); build01(); f1 = frm;
      rand01(); build01(); frm = {f1, frm};
      settle(0); wr0 = wr_seen; ok0 = ok_seen;
      send_frame(0, -1, 1'b1, f1.size(), ps);
      expect_commit01("b2b");
      chk("b2b_stall", 64'(ps), 64'd2);
      settle(2);
      chk("b2b_wr_count", 64'(wr_seen - wr0), 64'd2);
      chk("b2b_ok_count", 64'(ok_seen - ok0), 64'd2);

      // randomized mix of burst and preset frames
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(2, 0) != 0) begin
            rand01();
            good01("rnd01", 3, (k == 0) ? 17 : -1);
         end else begin
            t = {$urandom, $urandom}; build02(t);
            send_frame(3, -1, 1'b1, -1, ps);
            m_st = t;
            chk("rnd02_val", SYS_TIME, m_st);
            chk("rnd02_upd", 64'(SYS_TIME_UPDATE), 64'd1);
            SYS_TIME_UPDATE_OK = 1'b1;
            @(negedge CLK);
            SYS_TIME_UPDATE_OK = 1'b0;
            @(negedge CLK);
            chk("rnd02_ack", 64'(SYS_TIME_UPDATE), 64'd0);
            check_mem("rnd02_memkeep");
         end
      end

      // error counter saturation
      for (int k = 0; k < 260; k++) begin
         send_byte(HB, 0, st);
         send_byte(8'h7F, 0, st);
         model_err();
      end
      rx_valid = 1'b0;
      settle(2);
      chk("sat_errcnt", 64'(err_cnt), 64'(m_errs));
      chk("sat_value", 64'(err_cnt), 64'd255);
      check_mem("sat_memkeep");

      // reset in the middle of a payload
      rand01(); build01();
      for (int i = 0; i < 12; i++) send_byte(frm[i], 0, st);
      rx_valid = 1'b0;
      wr0 = wr_seen;
      RESET = 1'b1;
      @(negedge CLK);
      model_clear();
      check_mem("mid_rst");
      chk("mid_rst_systime", SYS_TIME, m_st);
      chk("mid_rst_errcnt", 64'(err_cnt), 64'(m_errs));
      chk("mid_rst_rdy", 64'(rx_ready), 64'd1);
      chk("mid_rst_wr", 64'(WR_DATA), 64'd0);
      RESET = 1'b0;
      settle(5);
      chk("mid_rst_no_wr", 64'(wr_seen - wr0), 64'd0);
      chk("mid_rst_no_ok", 64'(frame_ok), 64'd0);
      rand01();
      good01("after_rst", 1, -1);

      settle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/master_start_loader.md
# master_start_loader

Command-frame loader that drives the MASTER_START synchronizer's parameter-write interface. It accepts a byte stream from the host link (UART/SPI deframer) and checks the frame. It assembles burst parameters into shadow registers and commits them to the `MEM_*` outputs only when a frame is valid. It then pulses `WR_DATA` for one cycle, and it also arms the system-time preset (`SYS_TIME`/`SYS_TIME_UPDATE`) and holds it until MASTER_START acknowledges.

## Interface
- `TIMEOUT`, default 48000: maximum allowed gap, in clock cycles, between accepted bytes inside a frame (1 ms at 48 MHz).
- `HDR`, default 8'hA5: frame header byte.
- `CLK`  in  1  48 MHz system clock.
- `RESET`  in  1  Reset; one clock; reset is synchronous and active-high.
- `rx_data`  in  8  Incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  Loader can accept a byte. A byte transfers when `rx_valid && rx_ready`.
- `SYS_TIME_UPDATE_OK`  in  1  Acknowledge from MASTER_START that the time preset was applied.
- `MEM_DDS_freq` out 48, `MEM_DDS_delta_freq` out 48, `MEM_DDS_delta_rate` out 32, `MEM_TIME_START` out 64, `MEM_N_impuls` out 16, `MEM_TYPE_impulse` out 2, `MEM_Interval_Ti` out 32, `MEM_Interval_Tp` out 32, `MEM_Tblank1` out 32, `MEM_Tblank2` out 32: committed burst parameters.
- `WR_DATA`  out  1  One-cycle write strobe to MASTER_START.
- `SYS_TIME`  out  64  Committed time preset.
- `SYS_TIME_UPDATE`  out  1  Preset armed; held until acknowledged.
- `frame_ok`  out  1  One-cycle pulse on a good frame.
- `frame_err`  out  1  One-cycle pulse on a bad checksum, unknown command, or timeout.
- `err_cnt`  out  8  Saturating error counter.

## Operation
- Frame layout: `HDR`, CMD, payload, then CSUM (CSUM only when the checksum feature is compiled in). Payload fields are sent MSB first.
- CMD 8'h01, 43-byte payload, fields in this order:
  - freq: 6 bytes.
  - delta_freq: 6 bytes.
  - delta_rate: 4 bytes.
  - TIME_START: 8 bytes.
  - N_impuls: 2 bytes.
  - TYPE: 1 byte. Only bits [1:0] are used; bits [7:2] are ignored but still included in the checksum.
  - Ti: 4 bytes.
  - Tp: 4 bytes.
  - Tblank1: 4 bytes.
  - Tblank2: 4 bytes.
- CMD 8'h02, 8-byte payload: SYS_TIME.
- CSUM is the sum mod 256 of the CMD byte and all payload bytes.
- State machine:
  - IDLE: discard bytes that are not `HDR`. On `HDR`, go to CMD.
  - CMD: 8'h01 or 8'h02 loads the byte counter with the payload length and goes to PAYLOAD. Any other value pulses `frame_err` and returns to IDLE.
  - PAYLOAD: each byte shifts into the 64-bit or 344-bit shadow register. When the counter reaches 0, go to CSUM.
  - CSUM: on a match, go to COMMIT. On a mismatch, pulse `frame_err` and return to IDLE.
  - COMMIT: copy the shadow to the outputs, pulse `frame_ok`, then go to WR (for cmd 01) or IDLE (for cmd 02).
  - WR: `WR_DATA`=1 for one cycle, then go to IDLE.
- `rx_ready` is 1 in IDLE, CMD, PAYLOAD and CSUM, and 0 in COMMIT and WR. Upstream holds its byte while `rx_ready` is low.
- Timeout: a gap counter runs in CMD, PAYLOAD and CSUM and is cleared on each accepted byte. When it reaches `TIMEOUT`, pulse `frame_err` and return to IDLE. The shadow is discarded.
- `MEM_*` and `SYS_TIME` change only in COMMIT. A bad or aborted frame leaves them untouched.
- Time-preset handshake:
  - A cmd-02 commit sets `SYS_TIME_UPDATE`=1.
  - `SYS_TIME_UPDATE` clears on the cycle after `SYS_TIME_UPDATE_OK`=1 is sampled.
  - A new cmd-02 commit while the preset is armed overwrites `SYS_TIME` and keeps it armed.
  - If a commit and an OK occur in the same cycle, the commit wins and the preset stays armed.
- `err_cnt` increments on each `frame_err` pulse and saturates at 255.

## Timing
- Reset: all outputs are 0 except `rx_ready`=1, and the state is IDLE. This holds for a reset mid-frame too: a partial frame is discarded and no `WR_DATA` is issued.
- The last byte (CSUM) is accepted at cycle N. COMMIT occurs at N+1, where `MEM_*` and `frame_ok` update. `WR_DATA`=1 at N+2. `MEM_*` are therefore stable for at least 1 cycle before and during `WR_DATA`.
- `rx_ready` is low at N+1 and N+2, so the next byte can be accepted at N+3 at the earliest.
- `SYS_TIME_UPDATE` goes high at N+1 for cmd 02.
- `frame_err` fires on the cycle after the offending byte, or on the cycle the timeout counter hits `TIMEOUT`.

## Configuration
- `LOADER_CHECKSUM_EN` defined: the CSUM byte is expected and verified.
- Undefined: there is no CSUM state. The last payload byte goes directly to COMMIT, so `frame_ok` and COMMIT fall at (last payload byte)+1. Checksum errors are never reported; unknown CMD and timeout errors still are.

## Test plan
- Cmd-01 frame with freq=0x001000000000, step=0x000000100000, rate=0x100, TIME_START=0x12C0, N=1, TYPE=0, Ti=Tp=0x1800, Tb1=Tb2=0x180, valid CSUM → `MEM_*` equal these values at N+1, one `WR_DATA` pulse at N+2, `frame_ok`=1, `err_cnt`=0.
- Same frame with CSUM+1 → no `WR_DATA`, `MEM_*` unchanged, `frame_err` once, `err_cnt`=1.
- Frame stopped after 20 payload bytes, idle `TIMEOUT` cycles → `frame_err`, state IDLE. A following good frame commits normally.
- Cmd-02 with SYS_TIME=0x0000000000000005 → `SYS_TIME_UPDATE`=1. Pulse `SYS_TIME_UPDATE_OK` once → `SYS_TIME_UPDATE`=0 next cycle, `SYS_TIME`=5.
- `RESET` asserted in PAYLOAD → all outputs 0, `rx_ready`=1, no `WR_DATA`. Unknown CMD 8'h7F → `frame_err`, stray non-`HDR` bytes ignored.
- Back-to-back frames with `rx_valid` held high → `rx_ready` low for exactly 2 cycles after each CSUM, no byte lost, two `WR_DATA` pulses.
